// File: rtl/soc_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module      : soc_ram_bist
//  Description : March-style built-in self-test initiator for the single-port
//                data RAM. Writes a seeded pattern, read-verifies and inverts
//                it in ascending order, then read-verifies the inverted image
//                in descending order. Reports pass/fail, first failure and a
//                saturating error count.
//  Revision    : 1.0 - initial release
// ============================================================================
module soc_ram_bist #(
   parameter int AW    = 10,
   parameter int DEPTH = 1024
) (
   input  logic          mclk,
   input  logic          puc_rst,
   input  logic          start,
   input  logic [15:0]   pattern,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic [15:0]   fail_data,
   output logic [7:0]    err_count,
   output logic          ram_ena,
   output logic [1:0]    ram_wea,
   output logic [AW-1:0] ram_addra,
   output logic [15:0]   ram_dina,
   input  logic [15:0]   ram_douta
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR      = 3'd1,
      S_RD_A    = 3'd2,
      S_RD_B    = 3'd3,
      S_DN      = 3'd4,
      S_DN_LAST = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t        state;
   logic [AW-1:0] addr;
   logic [15:0]   pat_q;

   logic [AW-1:0] addr_inc;
   logic [AW-1:0] addr_dec;
   logic          chk_en;
   logic [AW-1:0] chk_addr;
   logic [15:0]   chk_exp;
   logic          mismatch;

   // Expected word for an address: zero-extended address XOR captured seed.
   function automatic logic [15:0] exp_val(input logic [AW-1:0] a, input logic [15:0] p);
      return 16'(a) ^ p;
   endfunction

   assign addr_inc = addr + AW'(1);
   assign addr_dec = addr - AW'(1);

   // Select which read result is checked this cycle and against what value.
   // In the descending phase the data arriving now belongs to the address
   // issued one cycle earlier, i.e. addr+1.
   always_comb begin
      chk_en   = 1'b0;
      chk_addr = addr;
      chk_exp  = 16'h0000;
      case (state)
         S_RD_B: begin
            chk_en  = 1'b1;
            chk_exp = exp_val(addr, pat_q);
         end
         S_DN: begin
            chk_en   = (addr != LAST_ADDR);
            chk_addr = addr_inc;
            chk_exp  = ~exp_val(addr_inc, pat_q);
         end
         S_DN_LAST: begin
            chk_en  = 1'b1;
            chk_exp = ~exp_val(addr, pat_q);
         end
         default: begin
            chk_en = 1'b0;
         end
      endcase
   end

   assign mismatch = chk_en && (ram_douta != chk_exp);

   // Sequencer: state, address walk, registered RAM port and status outputs.
   always_ff @(posedge mclk) begin
      if (puc_rst) begin
         state     <= S_IDLE;
         addr      <= '0;
         pat_q     <= 16'h0000;
         busy      <= 1'b0;
         done      <= 1'b0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= 16'h0000;
         err_count <= 8'h00;
         ram_ena   <= 1'b0;
         ram_wea   <= 2'b00;
         ram_addra <= '0;
         ram_dina  <= 16'h0000;
      end else begin
         done <= 1'b0;

         if (mismatch) begin
            if (err_count != 8'hFF) begin
               err_count <= err_count + 8'd1;
            end
            if (!fail) begin
               fail      <= 1'b1;
               fail_addr <= chk_addr;
               fail_data <= ram_douta;
            end
         end

         case (state)
            S_IDLE: begin
               ram_ena  <= 1'b0;
               ram_wea  <= 2'b00;
               ram_dina <= 16'h0000;
               if (start) begin
                  pat_q     <= pattern;
                  fail      <= 1'b0;
                  fail_addr <= '0;
                  fail_data <= 16'h0000;
                  err_count <= 8'h00;
                  busy      <= 1'b1;
                  addr      <= '0;
                  state     <= S_WR;
                  // First write: E(0) is the seed itself.
                  ram_ena   <= 1'b1;
                  ram_wea   <= 2'b11;
                  ram_addra <= '0;
                  ram_dina  <= pattern;
               end
            end

            S_WR: begin
               if (addr == LAST_ADDR) begin
                  addr      <= '0;
                  state     <= S_RD_A;
                  ram_ena   <= 1'b1;
                  ram_wea   <= 2'b00;
                  ram_addra <= '0;
                  ram_dina  <= 16'h0000;
               end else begin
                  addr      <= addr_inc;
                  ram_ena   <= 1'b1;
                  ram_wea   <= 2'b11;
                  ram_addra <= addr_inc;
                  ram_dina  <= exp_val(addr_inc, pat_q);
               end
            end

            S_RD_A: begin
               state     <= S_RD_B;
               ram_ena   <= 1'b1;
               ram_wea   <= 2'b11;
               ram_addra <= addr;
               ram_dina  <= ~exp_val(addr, pat_q);
            end

            S_RD_B: begin
               ram_ena  <= 1'b1;
               ram_wea  <= 2'b00;
               ram_dina <= 16'h0000;
               if (addr == LAST_ADDR) begin
                  state     <= S_DN;
                  ram_addra <= LAST_ADDR;
               end else begin
                  addr      <= addr_inc;
                  state     <= S_RD_A;
                  ram_addra <= addr_inc;
               end
            end

            S_DN: begin
               ram_wea  <= 2'b00;
               ram_dina <= 16'h0000;
               if (addr == '0) begin
                  state   <= S_DN_LAST;
                  ram_ena <= 1'b0;
               end else begin
                  addr      <= addr_dec;
                  ram_ena   <= 1'b1;
                  ram_addra <= addr_dec;
               end
            end

            S_DN_LAST: begin
               state    <= S_DONE;
               busy     <= 1'b0;
               done     <= 1'b1;
               ram_ena  <= 1'b0;
               ram_wea  <= 2'b00;
               ram_dina <= 16'h0000;
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               ram_ena <= 1'b0;
               ram_wea <= 2'b00;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_soc_ram_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_soc_ram_bist
//  Description : Self-checking bench for soc_ram_bist with behavioural RAM
//                models (fault injectable) and a march reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_soc_ram_bist;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   int ntests = 0;
   int nfail  = 0;

   // DEPTH=8 instance signals
   logic        start8, busy8, done8, fail8, ena8;
   logic [15:0] pat8, fdata8, din8, dout8;
   logic [9:0]  faddr8, addr8;
   logic [7:0]  err8;
   logic [1:0]  wea8;

   // DEPTH=256 instance signals
   logic        start256, busy256, done256, fail256, ena256;
   logic [15:0] pat256, fdata256, din256, dout256;
   logic [9:0]  faddr256, addr256;
   logic [7:0]  err256;
   logic [1:0]  wea256;

   soc_ram_bist #(.AW(10), .DEPTH(8)) u8 (
      .mclk(clk), .puc_rst(rst), .start(start8), .pattern(pat8),
      .busy(busy8), .done(done8), .fail(fail8), .fail_addr(faddr8),
      .fail_data(fdata8), .err_count(err8), .ram_ena(ena8), .ram_wea(wea8),
      .ram_addra(addr8), .ram_dina(din8), .ram_douta(dout8)
   );

   soc_ram_bist #(.AW(10), .DEPTH(256)) u256 (
      .mclk(clk), .puc_rst(rst), .start(start256), .pattern(pat256),
      .busy(busy256), .done(done256), .fail(fail256), .fail_addr(faddr256),
      .fail_data(fdata256), .err_count(err256), .ram_ena(ena256), .ram_wea(wea256),
      .ram_addra(addr256), .ram_dina(din256), .ram_douta(dout256)
   );

   // Fault configuration for the DEPTH=8 RAM: 0 none, 1 stuck bit, 2 reads zero
   int   fk8 = 0;
   int   fa8 = 0;
   int   fb8 = 0;
   logic fv8 = 1'b0;

   function automatic logic [15:0] e_of(input int a, input logic [15:0] p);
      return 16'(a) ^ p;
   endfunction

   function automatic logic [15:0] apply_fault(input int kind, input int fa, input int fb,
                                               input logic fv, input int a, input logic [15:0] d);
      logic [15:0] r;
      r = d;
      if (kind == 2) r = 16'h0000;
      else if (kind == 1 && a == fa) r[fb] = fv;
      return r;
   endfunction

   // Behavioural RAMs: registered read, byte write enables, faults on read.
   logic [15:0] mem8   [0:1023];
   logic [15:0] mem256 [0:1023];

   always @(posedge clk) begin
      if (ena8) begin
         if (wea8[0]) mem8[addr8][7:0]  <= din8[7:0];
         if (wea8[1]) mem8[addr8][15:8] <= din8[15:8];
         if (wea8 == 2'b00) dout8 <= apply_fault(fk8, fa8, fb8, fv8, int'(addr8), mem8[addr8]);
      end
      if (ena256) begin
         if (wea256[0]) mem256[addr256][7:0]  <= din256[7:0];
         if (wea256[1]) mem256[addr256][15:8] <= din256[15:8];
         if (wea256 == 2'b00) dout256 <= apply_fault(2, 0, 0, 1'b0, int'(addr256), mem256[addr256]);
      end
   end

   // Free-running observers; the stimulus snapshots them around each run.
   int          bcnt8 = 0, bcnt256 = 0, dcnt8 = 0, wcnt8 = 0, viol = 0;
   logic [31:0] wlog8 [0:1023];

   always @(posedge clk) begin
      bcnt8   <= bcnt8 + (busy8 ? 1 : 0);
      bcnt256 <= bcnt256 + (busy256 ? 1 : 0);
      dcnt8   <= dcnt8 + (done8 ? 1 : 0);
      if (ena8 && wea8 == 2'b11) begin
         wlog8[wcnt8 % 1024] <= {6'b0, addr8, din8};
         wcnt8               <= wcnt8 + 1;
      end
      if ((wea8 == 2'b00 && din8 != 16'h0) || (wea256 == 2'b00 && din256 != 16'h0))
         viol <= viol + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: apply the march rules to an ideal memory seen through the fault.
   task automatic ref_run(input int depth, input logic [15:0] pat, input int kind, input int fa,
                          input int fb, input logic fv, output int errs, output logic rf,
                          output logic [9:0] ra, output logic [15:0] rd);
      logic [15:0] e, got;
      errs = 0; rf = 1'b0; ra = '0; rd = '0;
      for (int a = 0; a < depth; a++) begin
         e   = e_of(a, pat);
         got = apply_fault(kind, fa, fb, fv, a, e);
         if (got !== e) begin
            errs++;
            if (!rf) begin rf = 1'b1; ra = 10'(a); rd = got; end
         end
      end
      for (int a = depth - 1; a >= 0; a--) begin
         e   = ~e_of(a, pat);
         got = apply_fault(kind, fa, fb, fv, a, e);
         if (got !== e) begin
            errs++;
            if (!rf) begin rf = 1'b1; ra = 10'(a); rd = got; end
         end
      end
      if (errs > 255) errs = 255;
   endtask

   task automatic start_pulse8(input logic [15:0] pat);
      pat8   = pat;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      chk("start_busy", 32'(busy8), 32'd1);
      chk("start_cleared", 32'({fail8, err8}), 32'd0);
   endtask

   task automatic finish8(input logic [15:0] pat, input int b0, input int w0, input string tag);
      int          cyc, errs;
      logic        rf, wr_ok;
      logic [9:0]  ra;
      logic [15:0] rd;
      cyc = 0;
      while (done8 !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
      chk({tag, "_done"}, 32'(done8), 32'd1);
      chk({tag, "_busy_off"}, 32'(busy8), 32'd0);
      chk({tag, "_busy_len"}, 32'(bcnt8 - b0), 32'd33);
      ref_run(8, pat, fk8, fa8, fb8, fv8, errs, rf, ra, rd);
      chk({tag, "_fail"}, 32'(fail8), 32'(rf));
      chk({tag, "_err_count"}, 32'(err8), 32'(errs));
      chk({tag, "_fail_addr"}, 32'(faddr8), 32'(ra));
      chk({tag, "_fail_data"}, 32'(fdata8), 32'(rd));
      wr_ok = 1'b1;
      for (int a = 0; a < 8; a++)
         if (wlog8[(w0 + a) % 1024] !== {6'b0, 10'(a), e_of(a, pat)}) wr_ok = 1'b0;
      chk({tag, "_wr_seq"}, 32'(wr_ok), 32'd1);
      @(negedge clk);
      chk({tag, "_done_pulse"}, 32'(done8), 32'd0);
   endtask

   initial begin
      int          b0, w0, d0, cyc, errs;
      logic        rf, hit;
      logic [9:0]  ra;
      logic [15:0] rd, p, p2, t;

      start8 = 1'b0; pat8 = '0; start256 = 1'b0; pat256 = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy_done_fail", 32'({busy8, done8, fail8}), 32'd0);
      chk("rst_err_count", 32'(err8), 32'd0);
      chk("rst_ram_port", 32'({ena8, wea8, addr8, din8}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Good RAM, directed seed
      fk8 = 0;
      b0 = bcnt8; w0 = wcnt8;
      start_pulse8(16'hA5A5);
      finish8(16'hA5A5, b0, w0, "good");

      // Bit 3 of word 5 stuck at 0: only the inverted image exposes it
      fk8 = 1; fa8 = 5; fb8 = 3; fv8 = 1'b0;
      b0 = bcnt8; w0 = wcnt8;
      start_pulse8(16'hA5A5);
      finish8(16'hA5A5, b0, w0, "stuck5");
      chk("stuck5_addr_const", 32'(faddr8), 32'd5);
      chk("stuck5_data_const", 32'(fdata8), 32'h5A57);

      // Randomized seeds and faults
      for (int i = 0; i < 5; i++) begin
         p   = 16'($urandom);
         fk8 = int'($urandom_range(0, 2));
         fa8 = int'($urandom_range(0, 7));
         fb8 = int'($urandom_range(0, 15));
         fv8 = 1'($urandom);
         b0 = bcnt8; w0 = wcnt8;
         start_pulse8(p);
         finish8(p, b0, w0, "rand");
      end

      // Start held high with noise mid-run, then back-to-back run
      fk8 = 1; fa8 = 2; fb8 = int'($urandom_range(0, 15)); fv8 = 1'($urandom);
      p  = 16'($urandom);
      p2 = 16'($urandom);
      b0 = bcnt8; w0 = wcnt8;
      pat8 = p; start8 = 1'b1;
      @(negedge clk);
      chk("held_busy", 32'(busy8), 32'd1);
      repeat (12) begin
         @(negedge clk);
         start8 = 1'($urandom);
         pat8   = 16'($urandom);
      end
      start8 = 1'b1;
      pat8   = p2;
      finish8(p, b0, w0, "held1");
      b0 = bcnt8; w0 = wcnt8;
      @(negedge clk);
      start8 = 1'b0;
      chk("held2_busy", 32'(busy8), 32'd1);
      chk("held2_cleared", 32'({fail8, err8, faddr8, fdata8}), 32'd0);
      finish8(p2, b0, w0, "held2");

      // Reset during RD_B of address 3 after an earlier mismatch at address 1
      p   = 16'($urandom);
      fk8 = 1; fa8 = 1; fb8 = int'($urandom_range(0, 15));
      t   = e_of(1, p);
      fv8 = ~t[fb8];
      start_pulse8(p);
      hit = 1'b0; cyc = 0;
      while (!hit && cyc < 100) begin
         if (wea8 == 2'b11 && addr8 == 10'd3 && din8 == ~e_of(3, p)) hit = 1'b1;
         else begin @(negedge clk); cyc++; end
      end
      chk("rst_mid_reached", 32'(hit), 32'd1);
      chk("rst_mid_prefail", 32'({fail8, err8}), 32'h101);
      d0  = dcnt8;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_outputs", 32'({ena8, busy8, fail8, err8}), 32'd0);
      repeat (10) @(negedge clk);
      chk("rst_mid_no_done", 32'(dcnt8 - d0), 32'd0);
      fk8 = 0;
      b0 = bcnt8; w0 = wcnt8;
      start_pulse8(p);
      finish8(p, b0, w0, "after_rst");

      // DEPTH=256, RAM always reads zero: error count saturates
      b0 = bcnt256;
      pat256 = 16'hFFFF; start256 = 1'b1;
      @(negedge clk);
      start256 = 1'b0;
      cyc = 0;
      while (done256 !== 1'b1 && cyc < 1200) begin @(negedge clk); cyc++; end
      chk("sat_done", 32'(done256), 32'd1);
      chk("sat_busy_len", 32'(bcnt256 - b0), 32'd1025);
      ref_run(256, 16'hFFFF, 2, 0, 0, 1'b0, errs, rf, ra, rd);
      chk("sat_err_count", 32'(err256), 32'(errs));
      chk("sat_fail", 32'(fail256), 32'(rf));
      chk("sat_fail_addr", 32'(faddr256), 32'(ra));
      chk("sat_fail_data", 32'(fdata256), 32'(rd));

      chk("dina_zero_on_read", 32'(viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
`default_nettype wire
